// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the arbiter and the UART.
//   req_valid : per-requester "byte available" flags
//   req_data  : packed bytes, requester i in [i*DW +: DW]
//   req_ready : one-hot, single-cycle accept pulse
//   uart_en   : single-cycle start pulse to the UART
//   uart_data : byte presented to the UART
//   uart_done : UART transfer complete (level or pulse)
// The slave modport is the arbiter's view; the master modport is the
// surrounding system (producers plus UART).
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               uart_en;
  logic [DW-1:0]      uart_data;
  logic               uart_done;

  modport master (
    output req_valid, req_data, uart_done,
    input  req_ready, uart_en, uart_data
  );

  modport slave (
    input  req_valid, req_data, uart_done,
    output req_ready, uart_en, uart_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmit engine among NREQ
// byte producers.
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high
//   bus         : handshake bundle (slave side), see uart_tx_arbiter_if
//   grant_id    : index of the last granted requester
//   busy        : high whenever the FSM is not IDLE
//   timeout_err : sticky flag, set when uart_done never arrived in time
// All outputs are registered. The IDLE->ISSUE edge raises req_ready and loads
// uart_data/grant_id; the ISSUE->WAIT edge raises uart_en, so the start pulse
// appears one cycle after the accept pulse and coincides with the first WAIT
// cycle (wait counter = 0).
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  uart_tx_arbiter_if.slave        bus,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_err
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state, state_d;
  logic [GW-1:0]   last_grant;
  logic [CW-1:0]   wait_cnt;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic            uart_en_q, uart_en_d;
  logic [DW-1:0]   uart_data_q;
  logic            load, tmo_hit;

  logic [DW-1:0]   req_bytes [NREQ];
  logic [GW-1:0]   cand, pick;
  logic            found;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_bytes[i] = bus.req_data[i*DW +: DW];
  end

  // Circular search starting just after the previous winner, so the most
  // recently served requester has the lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d     = state;
    req_ready_d = '0;
    uart_en_d   = 1'b0;
    load        = 1'b0;
    tmo_hit     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_d           = ISSUE;
          req_ready_d[pick] = 1'b1;
          load              = 1'b1;
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        uart_en_d = 1'b1;
      end
      WAIT: begin
        // done takes priority over a timeout in the same cycle
        if (bus.uart_done) begin
          state_d = IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          state_d = IDLE;
          tmo_hit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= GW'(NREQ - 1);
      grant_id    <= '0;
      uart_data_q <= '0;
      req_ready_q <= '0;
      uart_en_q   <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_d;
      req_ready_q <= req_ready_d;
      uart_en_q   <= uart_en_d;
      if (load) begin
        uart_data_q <= req_bytes[pick];
        grant_id    <= pick;
        last_grant  <= pick;
      end
      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end
      // Counter idles at zero outside WAIT, so it always enters WAIT at 0.
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
    end
  end

  assign busy          = (state != IDLE);
  assign bus.req_ready = req_ready_q;
  assign bus.uart_en   = uart_en_q;
  assign bus.uart_data = uart_data_q;
endmodule
